// File: rtl/fifo66_pkg.sv
// Shared definitions for the 66-bit FIFO drain: length codes, FSM encoding,
// and the beat-formatting helpers used to load the output registers.
package fifo66_pkg;

    localparam int unsigned ENTRY_W = 66;
    localparam int unsigned BEAT_W  = 32;
    localparam int unsigned CNT_W   = 16;

    typedef enum logic [1:0] {
        LEN16 = 2'b00,
        LEN32 = 2'b01,
        LEN48 = 2'b10,
        LEN64 = 2'b11
    } len_code_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        BEAT0 = 2'b01,
        BEAT1 = 2'b10
    } state_e;

    typedef struct packed {
        logic [BEAT_W-1:0] data;
        logic              last;
        logic              half;
    } beat_t;

    // First beat carries payload[31:0]; short codes finish here.
    function automatic beat_t beat0_of(input logic [ENTRY_W-1:0] entry);
        beat_t b;
        case (len_code_e'(entry[65:64]))
            LEN16: begin
                b.data = {16'h0000, entry[15:0]};
                b.last = 1'b1;
                b.half = 1'b1;
            end
            LEN32: begin
                b.data = entry[31:0];
                b.last = 1'b1;
                b.half = 1'b0;
            end
            LEN48, LEN64: begin
                b.data = entry[31:0];
                b.last = 1'b0;
                b.half = 1'b0;
            end
            default: begin
                b.data = 32'h0000_0000;
                b.last = 1'b1;
                b.half = 1'b0;
            end
        endcase
        return b;
    endfunction

    // Second beat carries payload[63:32]; only reached for the 1x codes.
    function automatic beat_t beat1_of(input logic [ENTRY_W-1:0] entry);
        beat_t b;
        case (len_code_e'(entry[65:64]))
            LEN48: begin
                b.data = {16'h0000, entry[47:32]};
                b.half = 1'b1;
            end
            LEN64: begin
                b.data = entry[63:32];
                b.half = 1'b0;
            end
            default: begin
                b.data = 32'h0000_0000;
                b.half = 1'b0;
            end
        endcase
        b.last = 1'b1;
        return b;
    endfunction

endpackage

// File: rtl/fifo66_drain.sv
// Pops 66-bit length-coded entries from a FIFO read port and emits them as
// one or two 32-bit valid/ready beats, counting fully emitted entries.
module fifo66_drain
    import fifo66_pkg::*;
#(
    parameter int IN_W  = 66,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable_i,
    input  logic [IN_W-1:0]  fifo_data_i,
    input  logic             fifo_empty_i,
    output logic             fifo_rd_o,
    output logic [OUT_W-1:0] out_data_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             out_last_o,
    output logic             out_half_o,
    output logic             busy_o,
    output logic [15:0]      word_cnt_o
);

    state_e            state_q, state_d;
    logic [IN_W-1:0]   hold_q, hold_d;
    beat_t             beat_q, beat_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic accept_s;
    logic last_accept_s;
    logic fifo_rd_s;

    // Handshake terms; rst_n gates the pop so nothing is lost while in reset.
    always_comb begin
        accept_s      = (state_q != IDLE) & out_ready_i;
        last_accept_s = accept_s & beat_q.last;
        fifo_rd_s     = rst_n & enable_i & ~fifo_empty_i &
                        ((state_q == IDLE) | last_accept_s);
    end

    // Next-state, holding-register and output-register selection.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        beat_d  = beat_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (fifo_rd_s) begin
                    state_d = BEAT0;
                    hold_d  = fifo_data_i;
                    beat_d  = beat0_of(fifo_data_i);
                end else begin
                    state_d = IDLE;
                end
            end
            BEAT0, BEAT1: begin
                if (accept_s) begin
                    if (beat_q.last) begin
                        if (fifo_rd_s) begin
                            state_d = BEAT0;
                            hold_d  = fifo_data_i;
                            beat_d  = beat0_of(fifo_data_i);
                        end else begin
                            state_d = IDLE;
                            beat_d  = '0;
                        end
                    end else begin
                        state_d = BEAT1;
                        beat_d  = beat1_of(hold_q);
                    end
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = IDLE;
                beat_d  = '0;
            end
        endcase

        if (last_accept_s) begin
            cnt_d = cnt_q + 16'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State, holding entry, beat outputs and entry counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            hold_q  <= '0;
            beat_q  <= '0;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            beat_q  <= beat_d;
            cnt_q   <= cnt_d;
        end
    end

    assign fifo_rd_o   = fifo_rd_s;
    assign out_data_o  = beat_q.data;
    assign out_last_o  = beat_q.last;
    assign out_half_o  = beat_q.half;
    assign out_valid_o = (state_q != IDLE);
    assign busy_o      = (state_q != IDLE);
    assign word_cnt_o  = cnt_q;

endmodule

// File: tb/tb_fifo66_drain.sv
// Directed, table-driven bench for fifo66_drain with a queue-based FIFO model.
module tb_fifo66_drain;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable_i;
    logic [65:0] fifo_data_i;
    logic        fifo_empty_i;
    logic        fifo_rd_o;
    logic [31:0] out_data_o;
    logic        out_valid_o;
    logic        out_ready_i;
    logic        out_last_o;
    logic        out_half_o;
    logic        busy_o;
    logic [15:0] word_cnt_o;

    always #5 clk = ~clk;

    fifo66_drain #(.IN_W(66), .OUT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .enable_i(enable_i),
        .fifo_data_i(fifo_data_i), .fifo_empty_i(fifo_empty_i),
        .fifo_rd_o(fifo_rd_o), .out_data_o(out_data_o),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_last_o(out_last_o), .out_half_o(out_half_o),
        .busy_o(busy_o), .word_cnt_o(word_cnt_o)
    );

    typedef struct {
        logic [1:0]  code;
        logic [63:0] pay;
        logic        two;
        logic [31:0] d0;
        logic        l0;
        logic        h0;
        logic [31:0] d1;
        logic        h1;
    } vec_t;

    vec_t        vt[6];
    logic [65:0] fq[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] exp_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic refresh();
        if (fq.size() > 0) begin
            fifo_empty_i = 1'b0;
            fifo_data_i  = fq[0];
        end else begin
            fifo_empty_i = 1'b1;
            fifo_data_i  = 66'h0;
        end
    endtask

    task automatic push(input logic [65:0] e);
        fq.push_back(e);
        refresh();
    endtask

    // One clock: sample the pop request, let the edge pass, then update the FIFO model.
    task automatic tick();
        logic rd;
        #1;
        rd = fifo_rd_o;
        if (rd) chk("rd_while_empty", {63'h0, fifo_empty_i}, 64'h0);
        @(posedge clk);
        #1;
        if (rd && fq.size() > 0) fq.delete(0);
        refresh();
        @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_valid"}, {63'h0, out_valid_o}, 64'h0);
        chk({tag, "_data"},  {32'h0, out_data_o},  64'h0);
        chk({tag, "_last"},  {63'h0, out_last_o},  64'h0);
        chk({tag, "_half"},  {63'h0, out_half_o},  64'h0);
        chk({tag, "_busy"},  {63'h0, busy_o},      64'h0);
        chk({tag, "_cnt"},   {48'h0, word_cnt_o},  64'h0);
        chk({tag, "_rd"},    {63'h0, fifo_rd_o},   64'h0);
    endtask

    initial begin
        vt[0] = '{2'b11, 64'h0123_4567_89AB_CDEF, 1'b1, 32'h89AB_CDEF, 1'b0, 1'b0, 32'h0123_4567, 1'b0};
        vt[1] = '{2'b10, 64'h0000_5555_AAAA_BBBB, 1'b1, 32'hAAAA_BBBB, 1'b0, 1'b0, 32'h0000_5555, 1'b1};
        vt[2] = '{2'b00, 64'hFFFF_FFFF_FFFF_1234, 1'b0, 32'h0000_1234, 1'b1, 1'b1, 32'h0,         1'b0};
        vt[3] = '{2'b01, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, 32'hCAFE_F00D, 1'b1, 1'b0, 32'h0,         1'b0};
        vt[4] = '{2'b10, 64'h1111_2222_3333_4444, 1'b1, 32'h3333_4444, 1'b0, 1'b0, 32'h0000_2222, 1'b1};
        vt[5] = '{2'b11, 64'hFFFF_FFFF_0000_0000, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0};

        // Reset with a non-empty FIFO and enable high: no pop allowed.
        rst_n = 1'b0; enable_i = 1'b1; out_ready_i = 1'b1;
        fifo_data_i = 66'h0; fifo_empty_i = 1'b1;
        push({2'b01, 64'h1234_5678_9ABC_DEF0});
        @(negedge clk); @(negedge clk);
        #1;
        chk_reset_vals("reset");
        @(negedge clk);
        fq.delete(); refresh();
        rst_n = 1'b1;
        exp_cnt = 16'd0;
        tick();
        chk("idle_empty_valid", {63'h0, out_valid_o}, 64'h0);

        // Single entries through the table.
        for (int i = 0; i < 6; i++) begin
            push({vt[i].code, vt[i].pay});
            tick();
            chk($sformatf("v%0d_valid0", i), {63'h0, out_valid_o}, 64'h1);
            chk($sformatf("v%0d_data0", i),  {32'h0, out_data_o},  {32'h0, vt[i].d0});
            chk($sformatf("v%0d_last0", i),  {63'h0, out_last_o},  {63'h0, vt[i].l0});
            chk($sformatf("v%0d_half0", i),  {63'h0, out_half_o},  {63'h0, vt[i].h0});
            tick();
            if (vt[i].two) begin
                chk($sformatf("v%0d_valid1", i), {63'h0, out_valid_o}, 64'h1);
                chk($sformatf("v%0d_data1", i),  {32'h0, out_data_o},  {32'h0, vt[i].d1});
                chk($sformatf("v%0d_last1", i),  {63'h0, out_last_o},  64'h1);
                chk($sformatf("v%0d_half1", i),  {63'h0, out_half_o},  {63'h0, vt[i].h1});
                tick();
            end
            exp_cnt = exp_cnt + 16'd1;
            chk($sformatf("v%0d_cnt", i),   {48'h0, word_cnt_o},  {48'h0, exp_cnt});
            chk($sformatf("v%0d_idle", i),  {63'h0, out_valid_o}, 64'h0);
        end

        // Four LEN32 entries back to back.
        begin
            logic [5:0] rd_hist;
            logic [5:0] val_hist;
            int         k;
            rd_hist = 6'b0; val_hist = 6'b0; k = 0;
            for (int i = 0; i < 4; i++) push({2'b01, 32'h0BAD_0000, 32'hC0DE_0000 + 32'(i)});
            for (int c = 0; c < 6; c++) begin
                #1;
                rd_hist[c]  = fifo_rd_o;
                val_hist[c] = out_valid_o;
                if (out_valid_o) begin
                    chk($sformatf("b2b_data%0d", k), {32'h0, out_data_o}, {32'h0, 32'hC0DE_0000 + 32'(k)});
                    k++;
                end
                tick();
            end
            chk("b2b_rd_pattern",    {58'h0, rd_hist},  64'h0F);
            chk("b2b_valid_pattern", {58'h0, val_hist}, 64'h1E);
            exp_cnt = exp_cnt + 16'd4;
            chk("b2b_cnt", {48'h0, word_cnt_o}, {48'h0, exp_cnt});
        end

        // Downstream stall during BEAT1 with another entry waiting.
        push({2'b11, 64'hAAAA_BBBB_CCCC_DDDD});
        push({2'b01, 64'h0000_0000_1357_9BDF});
        tick();
        chk("stall_beat0", {32'h0, out_data_o}, 64'hCCCC_DDDD);
        tick();
        out_ready_i = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk($sformatf("stall_data%0d", c),  {32'h0, out_data_o},  64'hAAAA_BBBB);
            chk($sformatf("stall_last%0d", c),  {63'h0, out_last_o},  64'h1);
            chk($sformatf("stall_valid%0d", c), {63'h0, out_valid_o}, 64'h1);
            chk($sformatf("stall_rd%0d", c),    {63'h0, fifo_rd_o},   64'h0);
            tick();
        end
        out_ready_i = 1'b1;
        #1;
        chk("stall_release_rd", {63'h0, fifo_rd_o}, 64'h1);
        tick();
        exp_cnt = exp_cnt + 16'd1;
        chk("stall_cnt",  {48'h0, word_cnt_o}, {48'h0, exp_cnt});
        chk("stall_next", {32'h0, out_data_o}, 64'h1357_9BDF);
        tick();
        exp_cnt = exp_cnt + 16'd1;

        // Enable dropped mid-entry: finish it, then stop popping.
        push({2'b11, 64'h1111_1111_2222_2222});
        push({2'b01, 64'h0000_0000_3333_3333});
        tick();
        enable_i = 1'b0;
        tick();
        #1;
        chk("en_off_beat1", {32'h0, out_data_o}, 64'h1111_1111);
        chk("en_off_rd",    {63'h0, fifo_rd_o},  64'h0);
        tick();
        exp_cnt = exp_cnt + 16'd1;
        chk("en_off_idle",  {63'h0, out_valid_o}, 64'h0);
        chk("en_off_fifo",  64'(fq.size()),       64'h1);
        chk("en_off_cnt",   {48'h0, word_cnt_o},  {48'h0, exp_cnt});
        tick();
        chk("en_off_still_idle", {63'h0, out_valid_o}, 64'h0);
        enable_i = 1'b1;
        tick();
        chk("en_on_data", {32'h0, out_data_o}, 64'h3333_3333);
        tick();
        exp_cnt = exp_cnt + 16'd1;
        chk("en_on_cnt", {48'h0, word_cnt_o}, {48'h0, exp_cnt});

        // Reset pulsed during BEAT1 discards the entry.
        push({2'b11, 64'h5A5A_5A5A_A5A5_A5A5});
        tick();
        tick();
        out_ready_i = 1'b0;
        #1;
        chk("rst_mid_pre_data", {32'h0, out_data_o}, 64'h5A5A_5A5A);
        push({2'b01, 64'h0000_0000_7777_7777});
        rst_n = 1'b0;
        #1;
        chk_reset_vals("rst_mid");
        @(negedge clk);
        fq.delete(); refresh();
        rst_n = 1'b1; out_ready_i = 1'b1;
        exp_cnt = 16'd0;
        tick();
        chk("rst_mid_after_valid0", {63'h0, out_valid_o}, 64'h0);
        tick();
        chk("rst_mid_after_valid1", {63'h0, out_valid_o}, 64'h0);
        chk("rst_mid_after_cnt",    {48'h0, word_cnt_o},  64'h0);

        // Counter wrap: 65535 single-beat entries then one more.
        begin
            int guard;
            for (int i = 0; i < 65535; i++) fq.push_back({2'b00, 48'h0, 16'(i)});
            refresh();
            guard = 0;
            tick();
            while ((fq.size() > 0 || out_valid_o) && guard < 70000) begin
                tick();
                guard++;
            end
            chk("wrap_timeout", {63'h0, guard < 70000}, 64'h1);
            chk("wrap_ffff", {48'h0, word_cnt_o}, 64'hFFFF);
            push({2'b00, 64'h0000_0000_0000_BEEF});
            tick();
            chk("wrap_last_data", {32'h0, out_data_o}, 64'h0000_BEEF);
            tick();
            chk("wrap_zero", {48'h0, word_cnt_o}, 64'h0000);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
